// File: rtl/qtr_ttd_sampler_if.sv
// Bundles the control/result side of the QTR time-to-decay sampler.
// The slave modport is the sampler itself; master is its consumer.
interface qtr_ttd_sampler_if;
    logic [7:0]   channel_sel;
    logic         ir_evenLED;
    logic         ir_oddLED;
    logic [135:0] ttd_flat;
    logic         ttd_valid;
    logic         busy;

    modport master (
        output channel_sel,
        input  ir_evenLED,
        input  ir_oddLED,
        input  ttd_flat,
        input  ttd_valid,
        input  busy
    );

    modport slave (
        input  channel_sel,
        output ir_evenLED,
        output ir_oddLED,
        output ttd_flat,
        output ttd_valid,
        output busy
    );
endinterface

// File: rtl/qtr_ttd_sampler.sv
// Drives an 8-channel QTR reflectance array and measures each channel's
// time-to-decay in WF_CLK cycles, publishing all eight values per frame.
module qtr_ttd_sampler #(
    parameter int unsigned CHARGE_CYC = 160,
    parameter logic [16:0] TIMEOUT    = 17'd48000,
    parameter logic [15:0] IDLE_CYC   = 16'd1600
) (
    input  logic              WF_CLK,
    input  logic              rst_n,
    inout  wire  [7:0]        ir_snsr,
    qtr_ttd_sampler_if.slave  bus
);
    localparam logic [16:0] IDLE_LAST   = {1'b0, IDLE_CYC} - 17'd1;
    localparam logic [16:0] CHARGE_LAST = 17'(CHARGE_CYC - 1);
    localparam logic [16:0] DECAY_LAST  = TIMEOUT - 17'd1;
    localparam logic [16:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {IDLE, CHARGE, DECAY, PUBLISH} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [16:0]       cnt;
    logic [16:0]       cnt_nxt;
    logic [7:0]        sel_q;
    logic [7:0]        sync_1;
    logic [7:0]        sync_2;
    logic [7:0]        done;
    logic [7:0]        low_now;
    logic [7:0][16:0]  ttd_w;
    logic [7:0][16:0]  ttd_final;
    logic              start_frame;
    logic              all_done;
    logic              decay_exit;
    logic              busy_int;

    // A channel finishes on the first cycle its synchronized node reads low.
    assign low_now     = (state == DECAY) ? (sel_q & ~done & ~sync_2) : 8'h00;
    assign all_done    = (((done | low_now) & sel_q) == sel_q);
    assign decay_exit  = all_done || (cnt == DECAY_LAST);
    assign start_frame = (state == IDLE) && (cnt == IDLE_LAST);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (cnt == IDLE_LAST) begin
                    state_nxt = CHARGE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 17'd1;
                end
            end
            CHARGE: begin
                if (cnt == CHARGE_LAST) begin
                    state_nxt = DECAY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 17'd1;
                end
            end
            DECAY: begin
                if (decay_exit) begin
                    state_nxt = PUBLISH;
                    cnt_nxt   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 17'd1;
                end
            end
            PUBLISH: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Final frame values: latched earlier, latched this cycle, or timed out.
    always_comb begin
        ttd_final = '0;
        for (int i = 0; i < 8; i++) begin
            if (sel_q[i]) begin
                if (done[i]) begin
                    ttd_final[i] = ttd_w[i];
                end else if (low_now[i]) begin
                    ttd_final[i] = cnt;
                end else begin
                    ttd_final[i] = TIMEOUT;
                end
            end
        end
    end

    always_ff @(posedge WF_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            sel_q        <= '0;
            sync_1       <= '0;
            sync_2       <= '0;
            done         <= '0;
            ttd_w        <= '0;
            bus.ttd_flat <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sync_1 <= ir_snsr;
            sync_2 <= sync_1;
            if (start_frame) begin
                sel_q <= bus.channel_sel;
                done  <= '0;
                ttd_w <= '0;
            end
            if (state == DECAY) begin
                done <= done | low_now;
                for (int i = 0; i < 8; i++) begin
                    if (low_now[i]) begin
                        ttd_w[i] <= cnt;
                    end
                end
                if (decay_exit) begin
                    bus.ttd_flat <= ttd_final;
                end
            end
        end
    end

    assign busy_int       = (state == CHARGE) || (state == DECAY);
    assign bus.busy       = busy_int;
    assign bus.ttd_valid  = (state == PUBLISH);
    assign bus.ir_evenLED = busy_int && (sel_q[0] || sel_q[2] || sel_q[4] || sel_q[6]);
    assign bus.ir_oddLED  = busy_int && (sel_q[1] || sel_q[3] || sel_q[5] || sel_q[7]);

    // Only selected nodes are pulled high, and only while charging.
    for (genvar g = 0; g < 8; g++) begin : g_drive
        assign ir_snsr[g] = ((state == CHARGE) && sel_q[g]) ? 1'b1 : 1'bz;
    end
endmodule

// File: tb/tb_qtr_ttd_sampler.sv
// Self-checking bench for qtr_ttd_sampler: models each sensor node as a
// capacitor that decays a chosen number of cycles after release.
`timescale 1ns/100ps
module tb_qtr_ttd_sampler;
    localparam int CHARGE_CYC = 160;
    localparam int TIMEOUT    = 48000;
    localparam int IDLE_CYC   = 1600;
    localparam int DECAY_REL  = IDLE_CYC + CHARGE_CYC;

    logic         WF_CLK = 1'b0;
    logic         rst_n;
    wire  [7:0]   ir_snsr;
    logic [7:0]   tb_en  = 8'h00;
    logic [7:0]   tb_val = 8'h00;
    int           vectors     = 0;
    int           miscompares = 0;
    int           dly [8];
    logic [135:0] prev_flat;

    qtr_ttd_sampler_if bus ();

    qtr_ttd_sampler dut (
        .WF_CLK  (WF_CLK),
        .rst_n   (rst_n),
        .ir_snsr (ir_snsr),
        .bus     (bus)
    );

    always #31.25 WF_CLK = ~WF_CLK;

    for (genvar g = 0; g < 8; g++) begin : g_node
        assign ir_snsr[g] = tb_en[g] ? tb_val[g] : 1'bz;
    end

    function automatic logic [7:0] highBits(input logic [7:0] v);
        logic [7:0] res;
        for (int i = 0; i < 8; i++) res[i] = (v[i] === 1'b1);
        return res;
    endfunction

    // Reported TTD = release-to-low delay plus the two synchronizer cycles, capped.
    function automatic int expTtd(input logic [7:0] sel, input int i);
        if (!sel[i]) return 0;
        if (dly[i] + 2 <= TIMEOUT - 1) return dly[i] + 2;
        return TIMEOUT;
    endfunction

    function automatic int expDecayLen(input logic [7:0] sel);
        int m = 0;
        if (sel == 8'h00) return 1;
        for (int i = 0; i < 8; i++) begin
            if (sel[i] && expTtd(sel, i) > m) m = expTtd(sel, i);
        end
        return (m + 1 > TIMEOUT) ? TIMEOUT : m + 1;
    endfunction

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Runs one frame from the first IDLE cycle; abort_at>0 resets that many cycles into DECAY.
    task automatic applyStimulus(input logic [7:0] sel, input logic [7:0] mid_sel, input int abort_at);
        int           idle_bad   = 0;
        int           charge_bad = 0;
        int           decay_bad  = 0;
        int           strobe_r   = -1;
        int           dlen;
        int           limit;
        bit           aborted    = 1'b0;
        logic [1:0]   leds;
        logic [135:0] exp_flat;
        dlen  = expDecayLen(sel);
        limit = DECAY_REL + dlen + 4;
        leds  = {|(sel & 8'hAA), |(sel & 8'h55)};
        exp_flat = '0;
        for (int i = 0; i < 8; i++) exp_flat[17*i +: 17] = 17'(expTtd(sel, i));
        bus.channel_sel = sel;
        for (int r = 0; r <= limit; r++) begin
            if (r > 0) @(negedge WF_CLK);
            if (r < IDLE_CYC) begin
                if (bus.busy !== 1'b0 || {bus.ir_oddLED, bus.ir_evenLED} !== 2'b00 ||
                    bus.ttd_valid !== 1'b0 || highBits(ir_snsr) != 8'h00 || bus.ttd_flat !== prev_flat)
                    idle_bad++;
            end else if (r < DECAY_REL) begin
                if (bus.busy !== 1'b1 || {bus.ir_oddLED, bus.ir_evenLED} !== leds ||
                    bus.ttd_valid !== 1'b0 || highBits(ir_snsr) != sel)
                    charge_bad++;
            end else if (abort_at > 0 && r == DECAY_REL + abort_at) begin
                aborted = 1'b1;
                break;
            end else begin
                if (bus.ttd_valid === 1'b1) begin
                    strobe_r = r;
                    break;
                end
                if (bus.busy !== 1'b1 || {bus.ir_oddLED, bus.ir_evenLED} !== leds ||
                    (highBits(ir_snsr) & ~sel) != 8'h00 || bus.ttd_flat !== prev_flat)
                    decay_bad++;
                if (r == DECAY_REL + 3) bus.channel_sel = mid_sel;
                for (int i = 0; i < 8; i++) begin
                    tb_en[i]  = sel[i];
                    tb_val[i] = ((r - DECAY_REL) < dly[i]);
                end
            end
        end
        checkOutput("idle_window_errs", idle_bad, 0);
        checkOutput("charge_window_errs", charge_bad, 0);
        checkOutput("decay_window_errs", decay_bad, 0);
        if (aborted) begin
            checkOutput("leds_before_abort", {bus.ir_oddLED, bus.ir_evenLED}, leds);
            checkOutput("busy_before_abort", bus.busy, 1);
            tb_en = 8'h00;
            rst_n = 1'b0;
            #1;
            checkOutput("abort_lines_hiz", highBits(ir_snsr), 0);
            checkOutput("abort_leds", {bus.ir_oddLED, bus.ir_evenLED}, 0);
            checkOutput("abort_busy", bus.busy, 0);
            checkOutput("abort_valid", bus.ttd_valid, 0);
            checkOutput("abort_flat_nonzero", longint'(bus.ttd_flat != '0), 0);
            repeat (3) @(negedge WF_CLK);
            rst_n     = 1'b1;
            prev_flat = '0;
        end else begin
            tb_en = 8'h00;
            checkOutput("strobe_cycle", strobe_r, DECAY_REL + dlen);
            checkOutput("busy_at_strobe", bus.busy, 0);
            checkOutput("leds_at_strobe", {bus.ir_oddLED, bus.ir_evenLED}, 0);
            for (int i = 0; i < 8; i++)
                checkOutput($sformatf("ttd%0d_sel%02h", i, sel), bus.ttd_flat[17*i +: 17], expTtd(sel, i));
            prev_flat = exp_flat;
            @(negedge WF_CLK);
            checkOutput("valid_one_cycle", bus.ttd_valid, 0);
            checkOutput("flat_hold_diff", longint'(bus.ttd_flat != exp_flat), 0);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.channel_sel = 8'h00;
        prev_flat       = '0;
        repeat (3) @(negedge WF_CLK);
        checkOutput("reset_flat_nonzero", longint'(bus.ttd_flat != '0), 0);
        checkOutput("reset_valid", bus.ttd_valid, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_leds", {bus.ir_oddLED, bus.ir_evenLED}, 0);
        checkOutput("reset_lines_hiz", highBits(ir_snsr), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) dly[i] = 100 * (i + 1);
        applyStimulus(8'hFF, 8'hFF, 0);

        for (int i = 0; i < 8; i++) dly[i] = 50;
        applyStimulus(8'h05, 8'($urandom), 0);

        // Channel 6 goes low exactly on the timeout cycle; channel 7 never decays.
        for (int i = 0; i < 8; i++) dly[i] = 10;
        dly[6] = TIMEOUT - 3;
        dly[7] = 1000000;
        applyStimulus(8'hFF, 8'($urandom), 0);

        applyStimulus(8'h00, 8'($urandom), 0);

        for (int i = 0; i < 8; i++) dly[i] = 100 * (i + 1);
        applyStimulus(8'hFF, 8'hFF, 300);
        applyStimulus(8'hFF, 8'($urandom), 0);

        for (int i = 0; i < 8; i++) dly[i] = $urandom_range(0, 300);
        applyStimulus(8'hFF, 8'h01, 0);
        for (int i = 0; i < 8; i++) dly[i] = $urandom_range(0, 300);
        applyStimulus(8'h01, 8'($urandom), 0);

        repeat (4) begin
            for (int i = 0; i < 8; i++) dly[i] = $urandom_range(0, 400);
            applyStimulus(8'($urandom), 8'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
